// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared direction type and keycode constants for sprite motion
package sprite_pkg;

  typedef enum logic [2:0] {
    DIR_NONE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_t;

  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  function automatic dir_t reverse_dir(input dir_t d);
    case (d)
      DIR_UP:    reverse_dir = DIR_DOWN;
      DIR_DOWN:  reverse_dir = DIR_UP;
      DIR_LEFT:  reverse_dir = DIR_RIGHT;
      DIR_RIGHT: reverse_dir = DIR_LEFT;
      default:   reverse_dir = DIR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// rtl/frame_tick_sync.sv - two-flop synchroniser plus rising-edge detect giving a one-cycle frame tick
module frame_tick_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_tick
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
    end
  end

  assign o_tick = r_sync[1] & ~r_prev;

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - keyboard-driven sprite motion with speed ramp, pause and wall handling
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int KEYS         = 2,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int X_CENTER     = 320,
  parameter int Y_CENTER     = 240,
  parameter int SIZE         = 4,
  parameter int STEP         = 1,
  parameter int MAX_SPEED    = 8,
  parameter int ACCEL_FRAMES = 16,
  parameter int WALL_MODE    = 1
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic [8*KEYS-1:0]   keycode,
  output logic [COORD_W-1:0]  BallX,
  output logic [COORD_W-1:0]  BallY,
  output logic [COORD_W-1:0]  BallS,
  output dir_t                Dir,
  output logic                Paused,
  output logic                Bounce
);

  localparam int CW     = COORD_W + 2;
  localparam int HOLD_W = $clog2(ACCEL_FRAMES) + 1;

  localparam logic signed [CW-1:0] XMIN_S = CW'(X_MIN);
  localparam logic signed [CW-1:0] XMAX_S = CW'(X_MAX);
  localparam logic signed [CW-1:0] YMIN_S = CW'(Y_MIN);
  localparam logic signed [CW-1:0] YMAX_S = CW'(Y_MAX);
  localparam logic signed [CW-1:0] SIZE_S = CW'(SIZE);

  localparam logic [COORD_W-1:0] CLAMP_XL = COORD_W'(X_MIN + SIZE);
  localparam logic [COORD_W-1:0] CLAMP_XR = COORD_W'(X_MAX - SIZE);
  localparam logic [COORD_W-1:0] CLAMP_YT = COORD_W'(Y_MIN + SIZE);
  localparam logic [COORD_W-1:0] CLAMP_YB = COORD_W'(Y_MAX - SIZE);
  localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] MAX_C    = COORD_W'(MAX_SPEED);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ACCEL_FRAMES - 1);

  logic [COORD_W-1:0] r_x, r_y, r_speed;
  logic [HOLD_W-1:0]  r_hold;
  dir_t               r_dir;
  logic               r_paused, r_bounce, r_space_prev;

  logic               w_tick, w_space, w_hit;
  dir_t               w_req, w_dir_k, w_dir_n;
  logic [COORD_W-1:0] w_speed_k, w_speed_n, w_x_n, w_y_n;
  logic [COORD_W:0]   w_sum;
  logic [HOLD_W-1:0]  w_hold_k, w_hold_n;
  logic signed [CW-1:0] w_spd_s, w_x_t, w_y_t;

  frame_tick_sync u_tick (
    .i_clk   (Clk),
    .i_reset (Reset),
    .i_async (frame_clk),
    .o_tick  (w_tick)
  );

  // Scan from the highest slot down so the lowest-numbered match wins.
  always_comb begin
    w_req   = DIR_NONE;
    w_space = 1'b0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      case (keycode[8*i +: 8])
        KC_W:    w_req = DIR_UP;
        KC_A:    w_req = DIR_LEFT;
        KC_S:    w_req = DIR_DOWN;
        KC_D:    w_req = DIR_RIGHT;
        KC_SPACE: w_space = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_sum     = {1'b0, r_speed} + {1'b0, STEP_C};
    w_dir_k   = r_dir;
    w_speed_k = r_speed;
    w_hold_k  = '0;
    if (w_req != DIR_NONE) begin
      if (w_req != r_dir) begin
        w_dir_k   = w_req;
        w_speed_k = STEP_C;
      end else if (r_hold == HOLD_LAST) begin
        w_speed_k = (w_sum > {1'b0, MAX_C}) ? MAX_C : w_sum[COORD_W-1:0];
      end else begin
        w_hold_k = r_hold + 1'b1;
      end
    end
  end

  // Widened signed arithmetic keeps an overshoot past 0 or the top bound visible.
  assign w_spd_s = $signed({2'b00, w_speed_k});
  assign w_x_t   = (w_dir_k == DIR_LEFT) ? $signed({2'b00, r_x}) - w_spd_s
                                         : $signed({2'b00, r_x}) + w_spd_s;
  assign w_y_t   = (w_dir_k == DIR_UP)   ? $signed({2'b00, r_y}) - w_spd_s
                                         : $signed({2'b00, r_y}) + w_spd_s;

  always_comb begin
    w_x_n = r_x;
    w_y_n = r_y;
    w_hit = 1'b0;
    case (w_dir_k)
      DIR_RIGHT: if (w_x_t + SIZE_S > XMAX_S) begin w_hit = 1'b1; w_x_n = CLAMP_XR; end
                 else w_x_n = w_x_t[COORD_W-1:0];
      DIR_LEFT:  if (w_x_t - SIZE_S < XMIN_S) begin w_hit = 1'b1; w_x_n = CLAMP_XL; end
                 else w_x_n = w_x_t[COORD_W-1:0];
      DIR_DOWN:  if (w_y_t + SIZE_S > YMAX_S) begin w_hit = 1'b1; w_y_n = CLAMP_YB; end
                 else w_y_n = w_y_t[COORD_W-1:0];
      DIR_UP:    if (w_y_t - SIZE_S < YMIN_S) begin w_hit = 1'b1; w_y_n = CLAMP_YT; end
                 else w_y_n = w_y_t[COORD_W-1:0];
      default: ;
    endcase
    w_dir_n   = w_dir_k;
    w_speed_n = w_speed_k;
    w_hold_n  = w_hold_k;
    if (w_hit) begin
      w_hold_n = '0;
      if (WALL_MODE != 0) begin
        w_dir_n = reverse_dir(w_dir_k);
      end else begin
        w_dir_n   = DIR_NONE;
        w_speed_n = '0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x          <= COORD_W'(X_CENTER);
      r_y          <= COORD_W'(Y_CENTER);
      r_speed      <= '0;
      r_hold       <= '0;
      r_dir        <= DIR_NONE;
      r_paused     <= 1'b0;
      r_bounce     <= 1'b0;
      r_space_prev <= 1'b0;
    end else begin
      r_bounce <= 1'b0;
      if (w_tick) begin
        r_space_prev <= w_space;
        if (w_space && !r_space_prev) r_paused <= ~r_paused;
        if (!r_paused) begin
          r_x      <= w_x_n;
          r_y      <= w_y_n;
          r_dir    <= w_dir_n;
          r_speed  <= w_speed_n;
          r_hold   <= w_hold_n;
          r_bounce <= w_hit;
        end
      end
    end
  end

  assign BallX  = r_x;
  assign BallY  = r_y;
  assign BallS  = COORD_W'(SIZE);
  assign Dir    = r_dir;
  assign Paused = r_paused;
  assign Bounce = r_bounce;

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - directed self-checking bench for sprite_mover in reflect and stop wall modes
module tb_sprite_mover;
  import sprite_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [15:0] keycode = 16'h0000;

  logic [9:0] x1, y1, s1, x0, y0, s0;
  dir_t       d1, d0;
  logic       p1, p0, b1, b0;

  int n_checks = 0;
  int n_fail   = 0;
  int b1_cnt   = 0;
  int b0_cnt   = 0;

  sprite_mover #(.ACCEL_FRAMES(4), .WALL_MODE(1)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .BallX(x1), .BallY(y1), .BallS(s1), .Dir(d1), .Paused(p1), .Bounce(b1)
  );

  sprite_mover #(.ACCEL_FRAMES(4), .WALL_MODE(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .BallX(x0), .BallY(y0), .BallS(s0), .Dir(d0), .Paused(p0), .Bounce(b0)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (b1) b1_cnt++;
    if (b0) b0_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    Reset = 1'b1; keycode = 16'h0000; frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (x1 !== 10'd320) begin n_fail++; $display("FAIL reset_x: got %0d want 320", x1); end
    n_checks++; if (y1 !== 10'd240) begin n_fail++; $display("FAIL reset_y: got %0d want 240", y1); end
    n_checks++; if (d1 !== DIR_NONE) begin n_fail++; $display("FAIL reset_dir: got %0d want 0", d1); end
    n_checks++; if (p1 !== 1'b0) begin n_fail++; $display("FAIL reset_paused: got %b want 0", p1); end
    n_checks++; if (b1 !== 1'b0) begin n_fail++; $display("FAIL reset_bounce: got %b want 0", b1); end
    n_checks++; if (s1 !== 10'd4) begin n_fail++; $display("FAIL size: got %0d want 4", s1); end
  endtask

  task automatic test_right_move();
    keycode = 16'h0007;
    for (int k = 1; k <= 3; k++) begin
      do_tick();
      n_checks++; if (x1 !== 10'(320 + k)) begin n_fail++; $display("FAIL right_x%0d: got %0d want %0d", k, x1, 320 + k); end
    end
    n_checks++; if (d1 !== DIR_RIGHT) begin n_fail++; $display("FAIL right_dir: got %0d want 4", d1); end
    n_checks++; if (y1 !== 10'd240) begin n_fail++; $display("FAIL right_y: got %0d want 240", y1); end
  endtask

  task automatic test_accel();
    int exp_y[13] = '{239, 238, 237, 236, 234, 232, 230, 228, 225, 222, 219, 216, 212};
    keycode = 16'h001A;
    for (int k = 0; k < 13; k++) begin
      do_tick();
      n_checks++; if (y1 !== 10'(exp_y[k])) begin n_fail++; $display("FAIL accel_y%0d: got %0d want %0d", k + 1, y1, exp_y[k]); end
    end
    n_checks++; if (d1 !== DIR_UP) begin n_fail++; $display("FAIL accel_dir: got %0d want 1", d1); end
    n_checks++; if (x1 !== 10'd323) begin n_fail++; $display("FAIL accel_x: got %0d want 323", x1); end
  endtask

  task automatic test_slot_priority();
    keycode = 16'h0704;
    do_tick();
    n_checks++; if (d1 !== DIR_LEFT) begin n_fail++; $display("FAIL prio_dir: got %0d want 3", d1); end
    n_checks++; if (x1 !== 10'd322) begin n_fail++; $display("FAIL prio_x: got %0d want 322", x1); end
    keycode = 16'h0700;
    do_tick();
    n_checks++; if (d1 !== DIR_RIGHT) begin n_fail++; $display("FAIL slot1_dir: got %0d want 4", d1); end
    n_checks++; if (x1 !== 10'd323) begin n_fail++; $display("FAIL slot1_x: got %0d want 323", x1); end
    do_tick();
    n_checks++; if (x1 !== 10'd324) begin n_fail++; $display("FAIL slot1_x2: got %0d want 324", x1); end
    n_checks++; if (y1 !== 10'd212) begin n_fail++; $display("FAIL slot1_y: got %0d want 212", y1); end
  endtask

  task automatic test_reflect();
    int base1, base0;
    do_reset();
    keycode = 16'h0007;
    repeat (13) do_tick();
    n_checks++; if (x1 !== 10'd348) begin n_fail++; $display("FAIL ramp_x: got %0d want 348", x1); end
    keycode = 16'h0000;
    repeat (71) do_tick();
    n_checks++; if (x1 !== 10'd632) begin n_fail++; $display("FAIL coast_x: got %0d want 632", x1); end
    n_checks++; if (x0 !== 10'd632) begin n_fail++; $display("FAIL coast_x0: got %0d want 632", x0); end
    base1 = b1_cnt; base0 = b0_cnt;
    do_tick();
    n_checks++; if (x1 !== 10'd635) begin n_fail++; $display("FAIL reflect_x: got %0d want 635", x1); end
    n_checks++; if (d1 !== DIR_LEFT) begin n_fail++; $display("FAIL reflect_dir: got %0d want 3", d1); end
    n_checks++; if (b1_cnt !== base1 + 1) begin n_fail++; $display("FAIL reflect_bounce: got %0d cycles want 1", b1_cnt - base1); end
    n_checks++; if (x0 !== 10'd635) begin n_fail++; $display("FAIL stop_x: got %0d want 635", x0); end
    n_checks++; if (d0 !== DIR_NONE) begin n_fail++; $display("FAIL stop_dir: got %0d want 0", d0); end
    n_checks++; if (b0_cnt !== base0 + 1) begin n_fail++; $display("FAIL stop_bounce: got %0d cycles want 1", b0_cnt - base0); end
    do_tick();
    n_checks++; if (x1 !== 10'd631) begin n_fail++; $display("FAIL reflect_next_x: got %0d want 631", x1); end
    n_checks++; if (b1_cnt !== base1 + 1) begin n_fail++; $display("FAIL reflect_quiet: got %0d cycles want 1", b1_cnt - base1); end
    n_checks++; if (x0 !== 10'd635) begin n_fail++; $display("FAIL stop_hold_x: got %0d want 635", x0); end
  endtask

  task automatic test_stop_mode();
    int base0;
    do_reset();
    keycode = 16'h001A;
    repeat (13) do_tick();
    n_checks++; if (y0 !== 10'd212) begin n_fail++; $display("FAIL up_ramp_y0: got %0d want 212", y0); end
    keycode = 16'h0000;
    repeat (51) do_tick();
    n_checks++; if (y0 !== 10'd8) begin n_fail++; $display("FAIL up_coast_y0: got %0d want 8", y0); end
    base0 = b0_cnt;
    do_tick();
    n_checks++; if (y0 !== 10'd4 || d0 !== DIR_UP) begin n_fail++; $display("FAIL top_edge: got y=%0d dir=%0d want y=4 dir=1", y0, d0); end
    n_checks++; if (b0_cnt !== base0) begin n_fail++; $display("FAIL top_edge_bounce: got %0d want 0", b0_cnt - base0); end
    do_tick();
    n_checks++; if (y0 !== 10'd4 || d0 !== DIR_NONE) begin n_fail++; $display("FAIL top_hit: got y=%0d dir=%0d want y=4 dir=0", y0, d0); end
    n_checks++; if (b0_cnt !== base0 + 1) begin n_fail++; $display("FAIL top_hit_bounce: got %0d want 1", b0_cnt - base0); end
    do_tick();
    n_checks++; if (y0 !== 10'd4 || b0_cnt !== base0 + 1) begin n_fail++; $display("FAIL stopped: got y=%0d bounces=%0d want y=4 bounces=1", y0, b0_cnt - base0); end
    keycode = 16'h001A;
    do_tick();
    n_checks++; if (y0 !== 10'd4 || d0 !== DIR_NONE) begin n_fail++; $display("FAIL key_into_wall: got y=%0d dir=%0d want y=4 dir=0", y0, d0); end
    n_checks++; if (b0_cnt !== base0 + 2) begin n_fail++; $display("FAIL key_into_wall_bounce: got %0d want 2", b0_cnt - base0); end
    n_checks++; if (x0 !== 10'd320) begin n_fail++; $display("FAIL up_x0: got %0d want 320", x0); end
  endtask

  task automatic test_pause();
    do_reset();
    keycode = 16'h0007;
    do_tick();
    n_checks++; if (x1 !== 10'd321) begin n_fail++; $display("FAIL pre_pause_x: got %0d want 321", x1); end
    keycode = 16'h072C;
    do_tick();
    n_checks++; if (p1 !== 1'b1 || x1 !== 10'd322) begin n_fail++; $display("FAIL pause_on: got p=%b x=%0d want p=1 x=322", p1, x1); end
    for (int k = 0; k < 4; k++) begin
      do_tick();
      n_checks++; if (p1 !== 1'b1 || x1 !== 10'd322) begin n_fail++; $display("FAIL paused_hold%0d: got p=%b x=%0d want p=1 x=322", k, p1, x1); end
    end
    keycode = 16'h0007;
    do_tick();
    n_checks++; if (p1 !== 1'b1 || x1 !== 10'd322) begin n_fail++; $display("FAIL pause_release: got p=%b x=%0d want p=1 x=322", p1, x1); end
    keycode = 16'h072C;
    do_tick();
    n_checks++; if (p1 !== 1'b0 || x1 !== 10'd322) begin n_fail++; $display("FAIL pause_off: got p=%b x=%0d want p=0 x=322", p1, x1); end
    do_tick();
    n_checks++; if (p1 !== 1'b0 || x1 !== 10'd323) begin n_fail++; $display("FAIL resume: got p=%b x=%0d want p=0 x=323", p1, x1); end
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    frame_clk = 1'b0;
    @(posedge Clk);
    #1;
    n_checks++; if (x1 !== 10'd320 || y1 !== 10'd240) begin n_fail++; $display("FAIL mid_reset_pos: got %0d,%0d want 320,240", x1, y1); end
    n_checks++; if (p1 !== 1'b0 || b1 !== 1'b0 || d1 !== DIR_NONE) begin n_fail++; $display("FAIL mid_reset_state: got p=%b b=%b dir=%0d want 0 0 0", p1, b1, d1); end
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    n_checks++; if (x1 !== 10'd320) begin n_fail++; $display("FAIL post_reset_idle: got %0d want 320", x1); end
    do_tick();
    n_checks++; if (p1 !== 1'b1 || x1 !== 10'd321 || d1 !== DIR_RIGHT) begin n_fail++; $display("FAIL post_reset_tick: got p=%b x=%0d dir=%0d want p=1 x=321 dir=4", p1, x1, d1); end
  endtask

  initial begin
    test_reset();
    test_right_move();
    test_accel();
    test_slot_priority();
    test_reflect();
    test_stop_mode();
    test_pause();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
